// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants: default address width, depth and pointer width.
// Used by both the read-side and write-side pointer logic.
package fifo_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;
    localparam int PTR_W_DEF  = ADDR_W_DEF + 1;

    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Binary to reflected-Gray conversion, shared by both FIFO clock domains.
module binary_to_gray #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_bin,
    output logic [W-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_to_binary.sv
// Gray to binary conversion: each bit is the XOR of all Gray bits at or above it.
module gray_to_binary #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[W-1:i];
    end

endmodule

// File: rtl/rd_logic.sv
// Async FIFO read-side pointer, empty and underflow logic.
// Define RD_LEVEL_EN to add the registered rd_level / almost_empty outputs.
module rd_logic
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int AEMPTY_TH = 2
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic              empty,
    output logic              underflow,
    output logic [ADDR_W:0]   rd_level,
    output logic              almost_empty
);

    localparam int PTR_W = ptr_w(ADDR_W);

    if (ADDR_W < 1) begin : g_bad_aw
        $error("rd_logic: ADDR_W must be at least 1");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > 2 ** ADDR_W) begin : g_bad_th
        $error("rd_logic: AEMPTY_TH outside 0..DEPTH");
    end

    logic [PTR_W-1:0] r_rq1;
    logic [PTR_W-1:0] r_rq2;
    logic [PTR_W-1:0] r_rbin;
    logic [PTR_W-1:0] r_rgray;
    logic             r_empty;
    logic             r_underflow;
    logic             w_rd_acc;
    logic [PTR_W-1:0] w_rbin_next;
    logic [PTR_W-1:0] w_rgray_next;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_rq1 <= '0;
            r_rq2 <= '0;
        end else begin
            r_rq1 <= wr_ptr_gray;
            r_rq2 <= r_rq1;
        end
    end

    // Acceptance uses the registered flag, so a read on the edge where
    // empty falls is dropped rather than racing the sync chain.
    assign w_rd_acc    = rd_en & ~r_empty;
    assign w_rbin_next = r_rbin + {{ADDR_W{1'b0}}, w_rd_acc};

    binary_to_gray #(
        .W (PTR_W)
    ) u_b2g (
        .i_bin  (w_rbin_next),
        .o_gray (w_rgray_next)
    );

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_rbin      <= '0;
            r_rgray     <= '0;
            r_empty     <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_rbin  <= w_rbin_next;
            r_rgray <= w_rgray_next;
            r_empty <= (w_rgray_next == r_rq2);
            if (rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign rd_ptr      = r_rbin[ADDR_W-1:0];
    assign rd_ptr_gray = r_rgray;
    assign empty       = r_empty;
    assign underflow   = r_underflow;

`ifdef RD_LEVEL_EN
    localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AEMPTY_TH);

    logic [PTR_W-1:0] w_wbin_sync;
    logic [PTR_W-1:0] w_level_next;
    logic [PTR_W-1:0] r_level;
    logic             r_aempty;

    gray_to_binary #(
        .W (PTR_W)
    ) u_g2b (
        .i_gray (r_rq2),
        .o_bin  (w_wbin_sync)
    );

    assign w_level_next = w_wbin_sync - w_rbin_next;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_level  <= '0;
            r_aempty <= 1'b1;
        end else begin
            r_level  <= w_level_next;
            r_aempty <= (w_level_next <= AE_TH);
        end
    end

    assign rd_level     = r_level;
    assign almost_empty = r_aempty;
`else
    assign rd_level     = '0;
    assign almost_empty = r_empty;
`endif

endmodule

// File: tb/tb_rd_logic.sv
// Self-checking bench for rd_logic: directed scenarios plus random traffic
// against a read/write-count reference model.
module tb_rd_logic;

    localparam int AW   = 4;
    localparam int PW   = AW + 1;
    localparam int MODV = 2 ** PW;
    localparam int DEP  = 2 ** AW;
    localparam int TH   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rd_en = 1'b0;
    logic [PW-1:0] wr_g = '0;
    logic [AW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_gray;
    logic          empty;
    logic          underflow;
    logic [PW-1:0] rd_level;
    logic          almost_empty;

    rd_logic #(
        .ADDR_W    (AW),
        .AEMPTY_TH (TH)
    ) dut (
        .rd_clk       (clk),
        .rd_rst_n     (rst_n),
        .rd_en        (rd_en),
        .wr_ptr_gray  (wr_g),
        .rd_ptr       (rd_ptr),
        .rd_ptr_gray  (rd_ptr_gray),
        .empty        (empty),
        .underflow    (underflow),
        .rd_level     (rd_level),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: counts of entries written/read, write count seen 1 and 2 edges late.
    int m_r;
    int m_q1;
    int m_q2;
    int m_w;
    bit m_emp;
    bit m_uf;
    int m_lvl;
    bit m_ae;

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b % MODV);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_r   = 0;
        m_q1  = 0;
        m_q2  = 0;
        m_emp = 1'b1;
        m_uf  = 1'b0;
        m_lvl = 0;
        m_ae  = 1'b1;
    endtask

    task automatic model_edge();
        int acc;
        int rn;
        acc = (rd_en && !m_emp) ? 1 : 0;
        if (rd_en && m_emp) m_uf = 1'b1;
        rn    = (m_r + acc) % MODV;
        m_emp = (rn == m_q2);
`ifdef RD_LEVEL_EN
        m_lvl = (m_q2 - rn + MODV) % MODV;
        m_ae  = (m_lvl <= TH);
`else
        m_lvl = 0;
        m_ae  = m_emp;
`endif
        m_r  = rn;
        m_q2 = m_q1;
        m_q1 = m_w;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_ptr"}, 32'(rd_ptr), m_r % DEP);
        chk({tag, ".gray"}, 32'(rd_ptr_gray), 32'(gray(m_r)));
        chk({tag, ".empty"}, 32'(empty), 32'(m_emp));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_uf));
        chk({tag, ".level"}, 32'(rd_level), m_lvl);
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(m_ae));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic set_wr(input int w);
        m_w  = w % MODV;
        wr_g = gray(m_w);
    endtask

    // Assert reset between edges, check at once, release on a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        rd_en = 1'b0;
        #1 model_reset();
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_not_empty(input string tag);
        int n;
        n = 0;
        while (empty !== 1'b0 && n < 8) begin
            tick();
            n++;
        end
        chk(tag, n, 3);
    endtask

    initial begin
        int pw;
        int pr;
        set_wr(0);
        model_reset();
        do_reset();
        repeat (3) tick();

        set_wr(1);
        wait_not_empty("lat_first");
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("single.gray", 32'(rd_ptr_gray), 32'b00001);
        chk("single.empty", 32'(empty), 1);

        do_reset();
        set_wr(0);
        chk("uf.before", 32'(underflow), 0);
        rd_en = 1'b1;
        repeat (3) tick();
        chk("uf.ptr", 32'(rd_ptr), 0);
        chk("uf.set", 32'(underflow), 1);
        rd_en = 1'b0;
        repeat (2) tick();
        chk("uf.sticky", 32'(underflow), 1);

        do_reset();
        set_wr(16);
        wait_not_empty("lat_full");
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("full.ptr", 32'(rd_ptr), i);
            tick();
            chk("full.empty", 32'(empty), (i == 15) ? 1 : 0);
        end
        rd_en = 1'b0;
        chk("full.wrap", 32'(rd_ptr), 0);
        chk("full.gray", 32'(rd_ptr_gray), 32'b11000);
        chk("full.uf", 32'(underflow), 0);

        do_reset();
        set_wr(5);
        wait_not_empty("lat_five");
        rd_en = 1'b1;
        tick();
        tick();
`ifdef RD_LEVEL_EN
        chk("lvl3.level", 32'(rd_level), 3);
        chk("lvl3.aempty", 32'(almost_empty), 0);
`else
        chk("lvl3.level", 32'(rd_level), 0);
        chk("lvl3.aempty", 32'(almost_empty), 0);
`endif
        tick();
        rd_en = 1'b0;
`ifdef RD_LEVEL_EN
        chk("lvl2.level", 32'(rd_level), 2);
        chk("lvl2.aempty", 32'(almost_empty), 1);
`else
        chk("lvl2.level", 32'(rd_level), 0);
        chk("lvl2.aempty", 32'(almost_empty), 0);
`endif

        do_reset();
        set_wr(10);
        wait_not_empty("lat_ten");
        rd_en = 1'b1;
        repeat (7) tick();
        rd_en = 1'b0;
        chk("mid.ptr", 32'(rd_ptr), 7);
        do_reset();
        chk("mid.rst_ptr", 32'(rd_ptr), 0);
        chk("mid.rst_empty", 32'(empty), 1);
        wait_not_empty("lat_resync");

        do_reset();
        set_wr(0);
        pw = 1;
        pr = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                pw = $urandom_range(0, 3);
                pr = $urandom_range(0, 3);
            end
            rd_en = ($urandom_range(0, 3) < pr);
            if ($urandom_range(0, 3) < pw && ((m_w - m_r + MODV) % MODV) < DEP)
                set_wr(m_w + 1);
            tick();
        end
        rd_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rd_logic.md
RD_LOGIC -- requirements
Module: rd_logic

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, address width; FIFO depth is 2**ADDR_W.
REQ-002 SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold in entries (used only with RD_LEVEL_EN).
REQ-003 SHALL have one clock and an asynchronous active-low reset; the ports are listed below.
REQ-004 rd_clk  input  1  read-domain clock, rising edge.
REQ-005 rd_rst_n  input  1  asynchronous active-low reset.
REQ-006 rd_en  input  1  read request.
REQ-007 wr_ptr_gray  input  ADDR_W+1  write pointer in Gray code, driven from the write clock domain.
REQ-008 rd_ptr  output  ADDR_W  binary read address to the memory.
REQ-009 rd_ptr_gray  output  ADDR_W+1  registered Gray read pointer, sent to the write domain.
REQ-010 empty  output  1  registered empty flag.
REQ-011 underflow  output  1  sticky flag: a read was attempted while empty.
REQ-012 rd_level  output  ADDR_W+1  fill level seen by the read side (RD_LEVEL_EN only).
REQ-013 almost_empty  output  1  rd_level <= AEMPTY_TH (RD_LEVEL_EN only).

Function
REQ-014 SHALL synchronise wr_ptr_gray through two rd_clk flops, rq1 then rq2; rq2 is the synchronised write pointer.
REQ-015 SHALL keep a binary pointer rbin of width ADDR_W+1; rbin_next = rbin + (rd_en & ~empty), with modulo 2**(ADDR_W+1) wrap.
REQ-016 SHALL compute rgray_next = binary_to_gray(rbin_next).
REQ-017 On each rd_clk edge, SHALL register rbin <= rbin_next and rd_ptr_gray <= rgray_next.
REQ-018 SHALL drive rd_ptr = rbin[ADDR_W-1:0]; memory data for the accepted read is addressed by rd_ptr in the accept cycle.
REQ-019 SHALL register empty <= (rgray_next == rq2), so the flag updates in the same edge as the final read.
REQ-020 A read with rd_en=1 and empty=1 SHALL leave rbin and rd_ptr_gray unchanged and SHALL set underflow to 1.
REQ-021 underflow SHALL stay 1 until reset.
REQ-022 rd_en=1 on the edge where empty falls SHALL be ignored, because acceptance uses the registered empty.
REQ-023 From a wr_ptr_gray change to deassertion of empty SHALL take exactly 3 rd_clk edges (2 sync + 1 register).
REQ-024 rd_ptr SHALL wrap from 2**ADDR_W-1 to 0; the MSB of rbin SHALL toggle on each wrap.

Reset
REQ-025 While rd_rst_n is low, asynchronously: rbin, rd_ptr_gray, rq1, rq2 = 0; empty = 1; underflow = 0; rd_level = 0; almost_empty = 1.
REQ-026 Reset asserted mid-read SHALL abandon the read; reset deassertion SHALL be synchronised by the integrator.

Configuration
REQ-027 Macro RD_LEVEL_EN, defined: rd_level <= gray_to_binary(rq2) - rbin_next, modulo 2**(ADDR_W+1), registered; almost_empty <= (that level <= AEMPTY_TH), registered.
REQ-028 Macro RD_LEVEL_EN, undefined: rd_level tied to 0, almost_empty tied to empty, no gray_to_binary instance.

Structure
REQ-029 Package fifo_pkg SHALL hold the ADDR_W default, derived DEPTH, and the pointer-width constant shared with wr_logic.
REQ-030 SHALL instantiate the existing binary_to_gray.
REQ-031 New sub-module gray_to_binary (ADDR_W+1 bits, XOR prefix from the MSB down) SHALL be provided and shared.

Verification (ADDR_W=4, AEMPTY_TH=2)
REQ-032 Reset with rd_rst_n=0 mid-clock -> immediately empty=1, rd_ptr=0, rd_ptr_gray=00000, underflow=0, almost_empty=1.
REQ-033 wr_ptr_gray 00000->00001 at edge 0 -> empty=0 after edge 3; rd_en one cycle -> rd_ptr_gray=00001, empty=1 on the same edge.
REQ-034 wr_ptr_gray=11000 (gray of 16), 16 continuous reads -> rd_ptr 0..15 then 0, rd_ptr_gray=11000, empty=1 on 16th edge, underflow=0.
REQ-035 rd_en=1 held 3 cycles while empty -> rbin stays 0, underflow=1 and stays 1 after rd_en drops.
REQ-036 RD_LEVEL_EN, wr_ptr_gray=gray(5)=00111 settled, 3 reads -> rd_level=2, almost_empty=1; at rd_level=3 -> almost_empty=0.
REQ-037 rd_rst_n pulsed low after 7 reads -> rd_ptr=0, empty=1; after release, re-sync of an unchanged wr_ptr_gray reproduces the REQ-033 timing.
